// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART TX datapath among NUM_REQ producers; req_ready 1 cycle after grant, transfer_byte 3 cycles after grant.
// Holds each requester until its one-hot req_ready pulse; optional WAIT_BUSY watchdog under UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         tx_busy,
  output logic [DATA_W-1:0]            tx_data,
  output logic                         load_data_reg,
  output logic                         byte_ready,
  output logic                         transfer_byte,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         active,
  output logic [15:0]                  bytes_sent,
  output logic                         tx_err
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int GW  = $clog2(GUARD_CYCLES + 2);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0]  GUARD_LAST = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [WDW-1:0] WD_LAST    = WDW'(TIMEOUT_CYCLES - 1);

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_GUARD
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [15:0]        bytes_sent_q, bytes_sent_d;
  logic [GW-1:0]      guard_q, guard_d;
  logic [WDW-1:0]     wd_q, wd_d;
  logic               err_q, err_d;

  logic               pick_vld;
  logic [IW-1:0]      pick;
  logic [IW-1:0]      idx;
  logic [DATA_W-1:0]  pick_dat;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    pick_dat = '0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!pick_vld && req_valid[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
        pick_dat = req_data[idx*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    data_d       = data_q;
    bytes_sent_d = bytes_sent_q;
    guard_d      = guard_q;
    wd_d         = '0;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d  = pick;
          data_d   = pick_dat;
          rr_ptr_d = (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_ARM;
      S_ARM:   state_d = S_START;
      S_START: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (WD_EN) begin
          if (wd_q == WD_LAST) begin
            err_d   = 1'b1;
            guard_d = '0;
            state_d = (GUARD_CYCLES == 0) ? S_IDLE : S_GUARD;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          bytes_sent_d = bytes_sent_q + 16'd1;
          guard_d      = '0;
          state_d      = (GUARD_CYCLES == 0) ? S_IDLE : S_GUARD;
        end
      end
      S_GUARD: begin
        if (guard_q == GUARD_LAST) begin
          state_d = S_IDLE;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      data_q       <= '0;
      bytes_sent_q <= '0;
      guard_q      <= '0;
      wd_q         <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      data_q       <= data_d;
      bytes_sent_q <= bytes_sent_d;
      guard_q      <= guard_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
    end
  end

  assign req_ready     = (state_q == S_LOAD) ? (NUM_REQ'(1) << grant_q) : '0;
  assign load_data_reg = (state_q == S_LOAD);
  assign byte_ready    = (state_q == S_ARM) || (state_q == S_START);
  assign transfer_byte = (state_q == S_START);
  assign active        = (state_q != S_IDLE);
  assign grant_id      = grant_q;
  assign tx_data       = data_q;
  assign bytes_sent    = bytes_sent_q;
  assign tx_err        = err_q;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares one UART transmit datapath between NUM_REQ byte producers.
- Sits directly in front of the UART TX system top.
- Per byte, it sequences the datapath controls: load_data_reg, then byte_ready, then transfer_byte.
- Tracks the frame through tx_busy and enforces an idle guard gap between frames.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 8: byte width.
- GUARD_CYCLES, 2: idle clk cycles after tx_busy falls before the next grant (0 allowed).
- TIMEOUT_CYCLES, 64: watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte pending.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i uses bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- tx_busy  in  1  datapath frame in progress.
- tx_data  out  DATA_W  byte to the datapath data_in.
- load_data_reg  out  1  datapath data register load.
- byte_ready  out  1  datapath byte ready.
- transfer_byte  out  1  datapath start.
- grant_id  out  $clog2(NUM_REQ)  current/last granted requester.
- active  out  1  high in any state other than IDLE.
- bytes_sent  out  16  completed frames, wraps 0xFFFF->0.
- tx_err  out  1  watchdog error pulse.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; rr_ptr=0; guard and watchdog counters 0. Asserting reset mid-frame aborts immediately; no byte is counted.
- Outputs are decoded from registered state only; there are no combinational input-to-output paths.
- IDLE:
  - If any req_valid, select the first set bit searching from rr_ptr upward with wrap.
  - Register grant_id and tx_data<=req_data[grant]; set rr_ptr<=(grant+1) mod NUM_REQ; go to LOAD.
  - With no req_valid, stay in IDLE.
- LOAD (1 cycle): load_data_reg=1; req_ready[grant_id]=1 (the byte is accepted here). Next: ARM.
- ARM (1 cycle): byte_ready=1. Next: START.
- START (1 cycle): byte_ready=1, transfer_byte=1. Next: WAIT_BUSY.
- WAIT_BUSY: hold until tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: hold until tx_busy=0, then bytes_sent++ and go to GUARD. If GUARD_CYCLES=0, go straight to IDLE.
- GUARD: count GUARD_CYCLES cycles, then go to IDLE.
- Latency: req_valid sampled high in IDLE at edge N gives req_ready high in cycle N+1 and transfer_byte high in cycle N+3.
- tx_data is stable from LOAD until the next IDLE grant.
- Requester rule: hold req_valid and req_data until req_ready. If req_valid drops after the grant, the captured byte is still sent.
- req_valid changes outside IDLE are ignored until the return to IDLE.
- tx_busy already high in START is not sampled; WAIT_BUSY sees it on the next cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0...; no requester waits more than NUM_REQ-1 frames.
- rr_ptr advances only on a grant.

Optional Feature:
- Macro: UART_TX_SCHED_TIMEOUT_EN.
- Defined:
  - The watchdog counts cycles spent in WAIT_BUSY.
  - If the count reaches TIMEOUT_CYCLES with tx_busy still 0, tx_err pulses for 1 cycle, bytes_sent is not incremented, and the FSM goes to GUARD.
  - The counter clears on leaving WAIT_BUSY.
- Not defined: tx_err is tied to 0 and WAIT_BUSY waits indefinitely.

Test Plan:
1. Single byte: reset low 20ns then high; req_valid=4'b0001, req_data[7:0]=8'hA5; tx_busy model rises 2 cycles after transfer_byte and lasts 10 cycles -> req_ready=4'b0001 one cycle; tx_data=8'hA5; load_data_reg, byte_ready and transfer_byte on consecutive cycles; bytes_sent=1; 2 guard cycles before IDLE.
2. Round robin: all four valid with bytes 8'h11/22/33/44 held continuously -> frames go out in order 11,22,33,44,11; grant_id sequence 0,1,2,3,0.
3. Pointer wrap: rr_ptr=3 after a grant to requester 2; then req_valid=4'b0101 -> requester 0 granted before requester 2.
4. Reset mid-frame: drive rst=0 during WAIT_DONE -> all outputs 0 immediately; bytes_sent stays at its pre-reset value of 0; after release, a new request is granted to requester 0 first.
5. Timeout (macro defined, TIMEOUT_CYCLES=64): tx_busy held 0 -> tx_err pulses exactly 64 cycles after entering WAIT_BUSY; bytes_sent unchanged; next request is serviced normally.
6. Counter wrap: force bytes_sent=16'hFFFF, complete one frame -> bytes_sent=16'h0000.
